uart_baud_ctrl: RTL

//  Run-time controller for the UART oversample/bit tick timebase. Holds the active clock divisor.

---
 rtl/uart_baud_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_baud_ctrl.sv
// UART oversample/bit timebase with run-time divisor updates applied at bit boundaries.
// Optional mid-bit sample tick when UART_BAUD_MIDTICK_EN is defined.
module uart_baud_ctrl #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 326,
    parameter int OVER        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             resync,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             busy,
    output logic [DIV_W-1:0] cur_div,
    output logic             oversample_tick,
`ifdef UART_BAUD_MIDTICK_EN
    output logic             mid_tick,
`endif
    output logic             bit_tick
);
    localparam int OW = $clog2(OVER);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] div_cnt, div_cnt_n;
    logic [DIV_W-1:0] cur_div_n;
    logic [DIV_W-1:0] pend_div, pend_div_n;
    logic [OW-1:0]    over_cnt, over_cnt_n;
    logic             ost_n, bt_n, err_n;
    logic             xfer, div_ok, div_end, over_end, boundary;
`ifdef UART_BAUD_MIDTICK_EN
    logic             mid_n;
`endif

    assign cfg_ready = (state != PEND);
    assign busy      = (state == PEND);
    assign xfer      = cfg_valid & cfg_ready;
    assign div_ok    = (cfg_div >= DIV_W'(2));
    assign div_end   = (div_cnt == cur_div - DIV_W'(1));
    assign over_end  = (over_cnt == OW'(OVER - 1));

    always_comb begin
        state_n    = state;
        div_cnt_n  = div_cnt;
        over_cnt_n = over_cnt;
        cur_div_n  = cur_div;
        pend_div_n = pend_div;
        ost_n      = 1'b0;
        bt_n       = 1'b0;
        boundary   = 1'b0;
        err_n      = xfer & ~div_ok;
`ifdef UART_BAUD_MIDTICK_EN
        mid_n      = 1'b0;
`endif
        if (!en) begin
            state_n    = IDLE;
            div_cnt_n  = '0;
            over_cnt_n = '0;
            if (state == PEND)
                cur_div_n = pend_div;
            else if (xfer && div_ok)
                cur_div_n = cfg_div;
        end else begin
            // resync wins over terminal count and acts as a boundary
            if (resync) begin
                div_cnt_n  = '0;
                over_cnt_n = '0;
                boundary   = 1'b1;
            end else if (div_end) begin
                div_cnt_n = '0;
                ost_n     = 1'b1;
`ifdef UART_BAUD_MIDTICK_EN
                mid_n     = (over_cnt == OW'(OVER / 2 - 1));
`endif
                if (over_end) begin
                    over_cnt_n = '0;
                    bt_n       = 1'b1;
                    boundary   = 1'b1;
                end else begin
                    over_cnt_n = over_cnt + OW'(1);
                end
            end else begin
                div_cnt_n = div_cnt + DIV_W'(1);
            end

            unique case (state)
                IDLE: begin
                    state_n = RUN;
                    if (xfer && div_ok)
                        cur_div_n = cfg_div;
                end
                RUN: begin
                    if (xfer && div_ok) begin
                        pend_div_n = cfg_div;
                        state_n    = PEND;
                    end
                end
                PEND: begin
                    // counters are already zero on any boundary edge
                    if (boundary) begin
                        cur_div_n = pend_div;
                        state_n   = RUN;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            div_cnt         <= '0;
            over_cnt        <= '0;
            cur_div         <= DIV_W'(DEFAULT_DIV);
            pend_div        <= '0;
            oversample_tick <= 1'b0;
            bit_tick        <= 1'b0;
            cfg_err         <= 1'b0;
        end else begin
            state           <= state_n;
            div_cnt         <= div_cnt_n;
            over_cnt        <= over_cnt_n;
            cur_div         <= cur_div_n;
            pend_div        <= pend_div_n;
            oversample_tick <= ost_n;
            bit_tick        <= bt_n;
            cfg_err         <= err_n;
        end
    end

`ifdef UART_BAUD_MIDTICK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mid_tick <= 1'b0;
        else
            mid_tick <= mid_n;
    end
`endif

endmodule
